// File: rtl/plru_array_ctrl_pkg.sv
// Shared types for the PLRU replacement controller.
//   lc3b_plru    : 3-bit tree PLRU entry {b2 root, b1 ways 1/0, b0 ways 3/2}
//   lc3b_way     : 2-bit binary way index
//   plru_state_e : replacement FSM states
//   plru_victim  : tree victim decode of one entry
package plru_array_ctrl_pkg;

  typedef logic [2:0] lc3b_plru;
  typedef logic [1:0] lc3b_way;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    HOLD,
    UPDATE
  } plru_state_e;

  // b2 set means the victim lies in ways 2/3; b0/b1 pick within the half.
  function automatic lc3b_way plru_victim(input lc3b_plru e);
    if (e[2]) begin
      return e[0] ? 2'd3 : 2'd2;
    end else begin
      return e[1] ? 2'd1 : 2'd0;
    end
  endfunction

endpackage

// File: rtl/plru_next_state.sv
// Combinational MRU update of one tree PLRU entry.
// Ports:
//   entry      in   3  current PLRU entry
//   way        in   2  way just used (becomes MRU)
//   next_entry out  3  updated entry; the untouched sub-tree bit is preserved
// Victim decode of an entry is the package function plru_victim.
module plru_next_state
  import plru_array_ctrl_pkg::*;
(
  input  logic [2:0] entry,
  input  logic [1:0] way,
  output logic [2:0] next_entry
);

  // Point the root and the used half's bit away from the way just touched.
  always_comb begin
    next_entry = entry;
    unique case (way)
      2'd0:    next_entry = {2'b11, entry[0]};
      2'd1:    next_entry = {2'b10, entry[0]};
      2'd2:    next_entry = {1'b0, entry[1], 1'b1};
      default: next_entry = {1'b0, entry[1], 1'b0};
    endcase
  end

endmodule

// File: rtl/plru_array_ctrl.sv
// Per-set 4-way tree PLRU store and victim-selection controller.
// Records every hit/fill as MRU and hands a victim way to the cache FSM over a
// req/ack handshake (IDLE -> LOOKUP -> HOLD -> UPDATE -> IDLE).
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   acc_valid/set/way   hit on (set, way): mark MRU on the next edge, any state
//   repl_req/repl_set   victim request, accepted only in IDLE
//   fill_done           fill of repl_way complete, honoured only in HOLD
//   repl_ack            repl_way valid and frozen (HOLD)
//   repl_way            victim way
//   busy                FSM not in IDLE
//   way_valid           (PLRU_INVALID_FIRST_EN only) valid bits of the held set
// Config macro: PLRU_INVALID_FIRST_EN -- prefer the lowest invalid way as victim.
module plru_array_ctrl
  import plru_array_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        acc_valid,
  input  logic [$clog2(NUM_SETS)-1:0] acc_set,
  input  logic [1:0]                  acc_way,
  input  logic                        repl_req,
  input  logic [$clog2(NUM_SETS)-1:0] repl_set,
  input  logic                        fill_done,
`ifdef PLRU_INVALID_FIRST_EN
  input  logic [3:0]                  way_valid,
`endif
  output logic                        repl_ack,
  output logic [1:0]                  repl_way,
  output logic                        busy
);

  localparam int unsigned SET_W = $clog2(NUM_SETS);

  plru_state_e      state_q, state_d;
  logic [SET_W-1:0] held_set_q, held_set_d;
  lc3b_way          repl_way_q, repl_way_d;
  lc3b_plru         entry_q [NUM_SETS];

  lc3b_plru acc_next;    // access entry after the MRU update
  lc3b_plru held_eff;    // held-set entry including a same-cycle access
  lc3b_plru upd_next;    // held_eff with repl_way made MRU
  lc3b_way  victim;

  plru_next_state u_acc_next (
    .entry      (entry_q[acc_set]),
    .way        (acc_way),
    .next_entry (acc_next)
  );

  // Same-cycle access to the held set is folded in first, so neither the
  // LOOKUP victim nor the UPDATE write loses that access.
  always_comb begin
    held_eff = entry_q[held_set_q];
    if (acc_valid && (acc_set == held_set_q)) begin
      held_eff = acc_next;
    end
  end

  plru_next_state u_upd_next (
    .entry      (held_eff),
    .way        (repl_way_q),
    .next_entry (upd_next)
  );

`ifdef PLRU_INVALID_FIRST_EN
  always_comb begin
    victim = plru_victim(held_eff);
    if (!way_valid[0]) begin
      victim = 2'd0;
    end else if (!way_valid[1]) begin
      victim = 2'd1;
    end else if (!way_valid[2]) begin
      victim = 2'd2;
    end else if (!way_valid[3]) begin
      victim = 2'd3;
    end
  end
`else
  always_comb begin
    victim = plru_victim(held_eff);
  end
`endif

  always_comb begin
    state_d    = state_q;
    held_set_d = held_set_q;
    repl_way_d = repl_way_q;
    unique case (state_q)
      IDLE: begin
        if (repl_req) begin
          held_set_d = repl_set;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        repl_way_d = victim;
        state_d    = HOLD;
      end
      HOLD: begin
        if (fill_done) begin
          state_d = UPDATE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      held_set_q <= '0;
      repl_way_q <= '0;
    end else begin
      state_q    <= state_d;
      held_set_q <= held_set_d;
      repl_way_q <= repl_way_d;
    end
  end

  // UPDATE write to the held set already contains any same-cycle access to it;
  // an access to another set in that cycle proceeds independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SETS; i++) begin
        if ((state_q == UPDATE) && (held_set_q == SET_W'(i))) begin
          entry_q[i] <= upd_next;
        end else if (acc_valid && (acc_set == SET_W'(i))) begin
          entry_q[i] <= acc_next;
        end
      end
    end
  end

  assign repl_ack = (state_q == HOLD);
  assign repl_way = repl_way_q;
  assign busy     = (state_q != IDLE);

endmodule
